// File: rtl/sram_pkg.sv
// sram_pkg: SRAM bus widths, controller states and the client request record shared with the bus mux
package sram_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    typedef enum logic [1:0] {S_CLR_WR, S_CLR_GAP, S_SERVE} sram_state_t;
    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic                   we_n;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: single-cycle client port onto the async SRAM, zero-filling the delay region after reset or clear
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int CLEAR_DEPTH = 32000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we_n,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_drop,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_DEPTH - 1);
    sram_state_t       state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] wdata_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state       <= S_CLR_WR;
            clr_cnt     <= '0;
            o_drop      <= 1'b0;
            o_SRAM_ADDR <= '0;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b0;
            wdata_q     <= '0;
        end else begin
            o_drop <= i_req && (i_clear || state != S_SERVE);
            if (i_clear) begin
                // any write already on the pins finishes at this edge; the fill restarts next cycle
                state       <= S_CLR_WR;
                clr_cnt     <= '0;
                o_SRAM_WE_N <= 1'b1;
                o_SRAM_OE_N <= 1'b0;
            end else
                case (state)
                    S_CLR_WR: begin
                        o_SRAM_ADDR <= clr_cnt;
                        o_SRAM_WE_N <= 1'b0;
                        o_SRAM_OE_N <= 1'b1;
                        wdata_q     <= '0;
                        state       <= S_CLR_GAP;
                    end
                    S_CLR_GAP: begin
                        o_SRAM_WE_N <= 1'b1;
                        o_SRAM_OE_N <= 1'b0;
                        clr_cnt     <= clr_cnt == CLR_LAST ? '0 : clr_cnt + 1'b1;
                        state       <= clr_cnt == CLR_LAST ? S_SERVE : S_CLR_WR;
                    end
                    S_SERVE: begin
                        o_SRAM_WE_N <= ~i_req | i_we_n;
                        o_SRAM_OE_N <= i_req & ~i_we_n;
                        if (i_req) begin
                            o_SRAM_ADDR <= i_addr;
                            wdata_q     <= i_wdata;
                        end
                    end
                    default: state <= S_CLR_WR;
                endcase
        end
    assign o_ready     = state == S_SERVE;
    assign io_SRAM_DQ  = o_SRAM_WE_N ? 'z : wdata_q;
    assign o_rdata     = io_SRAM_DQ;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: vector table, hand-written corner sequences and randomized traffic against an async SRAM model
module tb_sram_port_ctrl;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CD = 4;
    localparam logic [DW-1:0] JUNK = 16'hD00D;

    logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, we_n = 1'b1, clear = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    wire  [DW-1:0] dq;
    logic [DW-1:0] rdata;
    logic [AW-1:0] s_addr;
    logic ready, drop, s_we_n, s_oe_n, s_ce_n, s_lb_n, s_ub_n;
    logic [DW-1:0] sram_mem [2**AW] = '{default: JUNK};
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_DEPTH(CD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_we_n(we_n),
        .i_wdata(wdata), .i_clear(clear), .o_rdata(rdata), .o_ready(ready), .o_drop(drop),
        .o_SRAM_ADDR(s_addr), .io_SRAM_DQ(dq), .o_SRAM_WE_N(s_we_n), .o_SRAM_OE_N(s_oe_n),
        .o_SRAM_CE_N(s_ce_n), .o_SRAM_LB_N(s_lb_n), .o_SRAM_UB_N(s_ub_n)
    );

    // async SRAM: drives DQ while reading, captures the word present at the end of each write cycle
    assign dq = (!s_ce_n && !s_oe_n && s_we_n) ? sram_mem[s_addr] : 'z;
    always @(posedge clk) if (!s_ce_n && !s_we_n) sram_mem[s_addr] <= dq;

    typedef struct {
        logic          req, we_n, clear;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          e_we_n, e_ready, e_drop;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_rdata;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        req = r; we_n = w; addr = a; wdata = d; clear = c;
    endtask

    task automatic wait_ready(input string name, output int n);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lows;
        logic [DW-1:0] ref_mem [16];
        int fill_left;
        // reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_we_n", 32'(s_we_n), 32'd1);
        chk("rst_oe_n", 32'(s_oe_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("tied_en", 32'({s_ce_n, s_lb_n, s_ub_n}), 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 2 * CD; c++) begin
            tick();
            chk("fill_we_n", 32'(s_we_n), 32'(c % 2 == 0));
            chk("fill_addr", 32'(s_addr), 32'((c - 1) / 2));
            chk("fill_ready", 32'(ready), 32'(c == 2 * CD));
        end
        for (int k = 0; k < CD; k++) chk("fill_zero", 32'(sram_mem[k]), 32'd0);
        chk("fill_beyond", 32'(sram_mem[CD]), 32'(JUNK));

        // single-cycle write, held read, write followed directly by a read
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'd5, 16'h1234, 1'b0, 1'b1, 1'b0, 8'd5, 16'h1234};
        vt[1] = '{1'b1, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd5, 16'h1234};
        vt[2] = '{1'b1, 1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd5, 16'h1234};
        vt[3] = '{1'b1, 1'b1, 1'b0, 8'd2, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd2, 16'h0000};
        vt[4] = '{1'b1, 1'b0, 1'b0, 8'd3, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8'd3, 16'hBEEF};
        vt[5] = '{1'b1, 1'b1, 1'b0, 8'd1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1, 16'h0000};
        vt[6] = '{1'b0, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1, 16'h0000};
        vt[7] = '{1'b1, 1'b1, 1'b0, 8'd3, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd3, 16'hBEEF};
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].req, vt[i].we_n, vt[i].addr, vt[i].wdata, vt[i].clear);
            tick();
            chk("vec_we_n", 32'(s_we_n), 32'(vt[i].e_we_n));
            chk("vec_addr", 32'(s_addr), 32'(vt[i].e_addr));
            chk("vec_rdata", 32'(rdata), 32'(vt[i].e_rdata));
            chk("vec_ready", 32'(ready), 32'(vt[i].e_ready));
            chk("vec_drop", 32'(drop), 32'(vt[i].e_drop));
        end

        // write then clear: the write lands, the fill wipes it, a request during the fill is dropped
        drive(1'b1, 1'b0, 8'd2, 16'h7FFF, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b1);
        tick();
        chk("clr_ready", 32'(ready), 32'd0);
        chk("clr_we_n", 32'(s_we_n), 32'd1);
        chk("clr_inflight", 32'(sram_mem[2]), 32'h7FFF);
        lows = 1;
        for (int k = 0; k < 20 && !ready; k++) begin
            drive(k == 2, 1'b0, 8'd9, 16'h5555, 1'b0);
            tick();
            chk("fill_drop", 32'(drop), 32'(k == 2));
            if (!ready) lows++;
        end
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b0);
        chk("clr_low_cycles", 32'(lows), 32'(2 * CD));
        chk("drop_no_write", 32'(sram_mem[9]), 32'(JUNK));
        drive(1'b1, 1'b1, 8'd2, 16'h0000, 1'b0);
        tick();
        chk("clr_read2", 32'(rdata), 32'd0);

        // clear and request together: clear wins and the request is dropped
        drive(1'b1, 1'b0, 8'd7, 16'h1111, 1'b1);
        tick();
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b0);
        chk("clrreq_drop", 32'(drop), 32'd1);
        chk("clrreq_ready", 32'(ready), 32'd0);
        wait_ready("clrreq_wait", n);
        drive(1'b1, 1'b1, 8'd7, 16'h0000, 1'b0);
        tick();
        chk("clrreq_read7", 32'(rdata), 32'(JUNK));

        // reset mid-fill while the third fill write is on the pins
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b1);
        tick();
        clear = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_addr", 32'(s_addr), 32'd2);
        chk("mid_we_n", 32'(s_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(s_we_n), 32'd1);
        chk("mid_rst_addr", 32'(s_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_addr", 32'(s_addr), 32'd0);
        chk("restart_we_n", 32'(s_we_n), 32'd0);
        wait_ready("restart_wait", n);
        chk("restart_len", 32'(n), 32'(2 * CD - 1));

        // randomized traffic against a word-array reference
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = 16'(a * 16'h0111) + 16'h4000;
            drive(1'b1, 1'b0, 8'(a), ref_mem[a], 1'b0);
            tick();
        end
        fill_left = 0;
        for (int c = 0; c < 400; c++) begin
            logic r, w, cl, rdy;
            logic [3:0] a;
            logic [DW-1:0] d;
            cl  = $urandom_range(0, 49) == 0;
            r   = $urandom_range(0, 3) != 0;
            w   = 1'($urandom_range(0, 1));
            a   = 4'($urandom_range(0, 15));
            d   = 16'($urandom);
            rdy = fill_left == 0;
            drive(r, w, {4'b0, a}, d, cl);
            tick();
            chk("rnd_drop", 32'(drop), 32'(r && (cl || !rdy)));
            if (cl) begin
                fill_left = 2 * CD;
                for (int k = 0; k < CD; k++) ref_mem[k] = '0;
            end else if (fill_left > 0) fill_left--;
            chk("rnd_ready", 32'(ready), 32'(fill_left == 0));
            if (r && !cl && rdy) begin
                chk("rnd_we_n", 32'(s_we_n), 32'(w));
                chk("rnd_addr", 32'(s_addr), 32'(a));
                chk("rnd_rdata", 32'(rdata), 32'(w ? ref_mem[a] : d));
                if (!w) ref_mem[a] = d;
            end else if (rdy && !cl) chk("rnd_idle_we_n", 32'(s_we_n), 32'd1);
        end
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b0);
        wait_ready("rnd_wait", n);
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b1, 8'(a), 16'h0000, 1'b0);
            tick();
            chk("final_read", 32'(rdata), 32'(ref_mem[a]));
        end
        drive(1'b0, 1'b1, 8'd0, 16'h0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
